// File: rtl/router_pkg.sv
// Shared types for the N-port router controller: state encoding, default parameters,
// and the Moore decode of each state onto the controller outputs.
package router_pkg;

    localparam int unsigned DEF_NUM_PORTS    = 3;
    localparam int unsigned DEF_ADDR_W       = 2;
    localparam int unsigned DEF_WAIT_TIMEOUT = 255;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
        logic drop_pkt;
    } state_out_t;

    // Output pattern presented while the controller sits in a given state.
    function automatic state_out_t decode_state(input state_t st);
        state_out_t o;
        o = '0;
        case (st)
            DECODE_ADDRESS:     o.detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                o.lfd_state = 1'b1;
                o.busy      = 1'b1;
            end
            LOAD_DATA: begin
                o.ld_state      = 1'b1;
                o.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                o.full_state = 1'b1;
                o.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                o.laf_state     = 1'b1;
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            LOAD_PARITY: begin
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                o.rst_int_reg = 1'b1;
                o.busy        = 1'b1;
            end
            WAIT_TILL_EMPTY:    o.busy     = 1'b1;
            DROP_PACKET:        o.drop_pkt = 1'b1;
            default:            o.detect_add = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY state; expire is high during the
// TIMEOUT-th consecutive enabled cycle after a clear.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Saturate at LAST so a lingering enable can never wrap the count.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != LAST)) begin
            count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count  <= '0;
            expire <= 1'b0;
        end else begin
            count  <= count_next;
            expire <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/router_nport_fsm.sv
// Packet-routing controller for NUM_PORTS destination FIFOs.
// Define ROUTER_WAIT_TIMEOUT_EN to bound the time spent in WAIT_TILL_EMPTY.
module router_nport_fsm
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 fifo_full,
    input  logic                 low_pkt_valid,
    input  logic                 parity_done,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addr_q,
    output logic                 drop_pkt,
    output logic                 timeout_err
);

    localparam int unsigned PORT_SPAN = 1 << ADDR_W;
    localparam int unsigned AW1       = ADDR_W + 1;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_next;
    state_out_t         outs_q;
    logic [PORT_SPAN-1:0] empty_ext;
    logic [PORT_SPAN-1:0] soft_ext;
    logic               addr_ok;
    logic               soft_hit;
    logic               expire;
    logic               tmo_fire;

    // Pad per-port flags to the full address span so any address indexes safely.
    assign empty_ext = PORT_SPAN'(fifo_empty);
    assign soft_ext  = PORT_SPAN'(soft_reset);
    assign addr_ok   = {1'b0, data_in} < AW1'(NUM_PORTS);
    assign soft_hit  = soft_ext[addr_q] && (state != DECODE_ADDRESS);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        tmo_fire   = 1'b0;
        if (soft_hit) begin
            state_next = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && addr_ok) begin
                        addr_next  = data_in;
                        state_next = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else if (pkt_valid) begin
                        state_next = DROP_PACKET;
                    end
                end
                LOAD_FIRST_DATA:  state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_next = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_next = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_next = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_next = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_next = LOAD_PARITY;
                    end else begin
                        state_next = LOAD_DATA;
                    end
                end
                LOAD_PARITY:      state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_ext[addr_q]) begin
                        state_next = LOAD_FIRST_DATA;
                    end else if (expire) begin
                        state_next = DROP_PACKET;
                        tmo_fire   = 1'b1;
                    end
                end
                DROP_PACKET: begin
                    if (!pkt_valid) begin
                        state_next = DECODE_ADDRESS;
                    end
                end
                default:          state_next = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match the present state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= '0;
            outs_q <= decode_state(DECODE_ADDRESS);
        end else begin
            addr_q <= addr_next;
            outs_q <= decode_state(state_next);
        end
    end

    assign detect_add    = outs_q.detect_add;
    assign lfd_state     = outs_q.lfd_state;
    assign ld_state      = outs_q.ld_state;
    assign laf_state     = outs_q.laf_state;
    assign full_state    = outs_q.full_state;
    assign rst_int_reg   = outs_q.rst_int_reg;
    assign write_enb_reg = outs_q.write_enb_reg;
    assign busy          = outs_q.busy;
    assign drop_pkt      = outs_q.drop_pkt;

`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    assign timer_clear  = (state != WAIT_TILL_EMPTY);
    assign timer_enable = (state == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    // One-cycle pulse aligned with the first DROP_PACKET cycle after a timeout.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
        end
    end
`else
    logic unused_cfg;

    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{tmo_fire, 32'(WAIT_TIMEOUT)};
`endif

endmodule
